rf_access_ctrl: RTL and testbench
=================================

Name: rf_access_ctrl

Overview:
Controller that owns the 8x4 register file's single write port and its display read port. It arbitrates writes between a switch-driven user requester and a built-in clear sequencer. It also runs the seven-segment digit scan that reads four register locations in turn for display. It sits between the switch/button logic and the register file plus seven-segment decoder inside the memory display top level.

Parameters:
ADDR_W, 3, register file address width (8 locations)
DATA_W, 4, register file data width (one hex digit)
REFRESH_DIV, 50000, clk cycles per displayed digit (set to 4 in simulation)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-low reset
usr_req  input  1  user write request, level, held until usr_ack
usr_addr  input  ADDR_W  user write address
usr_data  input  DATA_W  user write data
usr_ack  output  1  one-cycle pulse: user write committed
clr_start  input  1  start clearing all locations to zero (sampled level)
clr_busy  output  1  high while clear sequence runs
page  input  1  display page: 0 shows locations 0-3, 1 shows locations 4-7
rf_w_ena  output  1  register file write enable
rf_w_addr  output  ADDR_W  register file write address
rf_w_data  output  DATA_W  register file write data
rf_r_addr  output  ADDR_W  register file read address (display scan)
rf_r_data  input  DATA_W  register file combinational read data
digit_data  output  DATA_W  registered value for the seven-segment decoder
anode  output  4  digit enables, active-low, one-hot-zero

Behaviour:
- Reset (rst==0 at a clk edge) values:
  - FSM=IDLE; rf_w_ena=0, rf_w_addr=0, rf_w_data=0.
  - usr_ack=0, clr_busy=0.
  - Scan index=0, divider=0, anode=4'b1110, digit_data=0.
  - Reset mid-clear aborts the clear. Locations already written stay written.
- Write FSM states: IDLE, USER_WR, ACK_WAIT, CLEAR.
  - IDLE, clr_start=1 -> CLEAR. Clear has priority over usr_req asserted in the same cycle.
  - IDLE, usr_req=1 and armed=1 -> USER_WR.
  - USER_WR (1 cycle): rf_w_ena=1, rf_w_addr=usr_addr, rf_w_data=usr_data.
    - Next cycle: usr_ack=1 for exactly one cycle, armed cleared, FSM -> ACK_WAIT.
    - Net latency: req seen in IDLE -> write at +1 -> ack at +2.
  - ACK_WAIT: returns to IDLE the cycle after usr_ack.
  - armed re-sets only after usr_req is sampled low. A held request writes exactly once.
  - CLEAR: clr_busy=1, rf_w_ena=1, rf_w_data=0, rf_w_addr steps 0,1,...,7 on consecutive cycles (8 cycles).
    - After address 7: clr_busy=0, FSM -> IDLE.
    - clr_start held or re-asserted during CLEAR is ignored. A new clear needs clr_start high while in IDLE.
    - usr_req during CLEAR is held pending and serviced from IDLE after the clear (no ack during clear).
- Outside USER_WR and CLEAR: rf_w_ena=0; rf_w_addr and rf_w_data hold their last value.
- Scan (independent of the write FSM, runs every cycle):
  - Divider counts 0..REFRESH_DIV-1 and wraps. The wrap cycle produces a tick.
  - On each tick, index increments modulo 4 (3 -> 0).
  - rf_r_addr = {page, index[1:0]}, combinational from registered index and live page.
  - anode = ~(4'b0001 << index), registered with index.
  - digit_data is registered with rf_r_data every cycle, so it trails rf_r_addr by 1 cycle.
  - A page change is visible on digit_data 1 cycle later, with no scan restart.
- A write to the location currently being scanned appears on digit_data one cycle after the register file updates. No bypass is required.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> anode=1110, digit_data=0, usr_ack=0, clr_busy=0, rf_w_ena=0.
- User write: usr_req=1, usr_addr=5, usr_data=4'hA, held 6 cycles -> exactly one rf_w_ena pulse with addr 5, data A; one usr_ack pulse 2 cycles after req; q_regfile[5]=A.
- Clear: preload locations 0-7 with 1..8, pulse clr_start -> clr_busy high for 8 cycles, writes addr 0..7 with data 0, all locations read 0 afterwards.
- Contention: clr_start and usr_req (addr 2, data 7) asserted in the same cycle -> clear runs first; user write to addr 2 follows; final q_regfile[2]=7, all others 0.
- Scan (REFRESH_DIV=4): locations 4-7 = 1,2,3,4, page=1 -> anode sequence 1110,1101,1011,0111 every 4 cycles; digit_data 1,2,3,4; after index 3, wraps to 1110.
- Reset mid-clear: rst=0 at clear step 3 -> clr_busy=0 next edge; locations 0-2 (and 3 if written that edge) are 0, locations 4-7 keep their preload.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// Register-file access controller: arbitrates the single write port between
// user writes and a clear sequencer, and scans four locations for display.
module rf_wr_arb #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_req,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_data,
  output logic              usr_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              rf_w_ena,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_USER_WR  = 2'd1;
  localparam logic [1:0] S_ACK_WAIT = 2'd2;
  localparam logic [1:0] S_CLEAR    = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0] state;
  logic       armed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      rf_w_ena  <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      usr_ack   <= 1'b0;
      clr_busy  <= 1'b0;
      armed     <= 1'b1;
    end else begin
      usr_ack <= 1'b0;
      // A held request must drop before it can write again.
      if (!usr_req) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (clr_start) begin
            state     <= S_CLEAR;
            clr_busy  <= 1'b1;
            rf_w_ena  <= 1'b1;
            rf_w_addr <= '0;
            rf_w_data <= '0;
          end else if (usr_req && armed) begin
            state     <= S_USER_WR;
            rf_w_ena  <= 1'b1;
            rf_w_addr <= usr_addr;
            rf_w_data <= usr_data;
          end
        end
        S_USER_WR: begin
          rf_w_ena <= 1'b0;
          usr_ack  <= 1'b1;
          armed    <= 1'b0;
          state    <= S_ACK_WAIT;
        end
        S_ACK_WAIT: state <= S_IDLE;
        S_CLEAR: begin
          if (rf_w_addr == LAST_ADDR) begin
            rf_w_ena <= 1'b0;
            clr_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            rf_w_addr <= rf_w_addr + ADDR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

module rf_disp_scan #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              page,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_data,
  output logic [DATA_W-1:0] digit_data,
  output logic [3:0]        anode
);
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic             tick;

  assign tick      = (div == DIV_LAST);
  assign rf_r_addr = ADDR_W'({page, idx});

  always_ff @(posedge clk) begin
    if (!rst) begin
      div        <= '0;
      idx        <= 2'd0;
      anode      <= 4'b1110;
      digit_data <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        idx   <= idx + 2'd1;
        // Rotating the active-low one-hot keeps anode locked to idx.
        anode <= {anode[2:0], anode[3]};
      end
      digit_data <= rf_r_data;
    end
  end
endmodule

module rf_access_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_req,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_data,
  output logic              usr_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              page,
  output logic              rf_w_ena,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_data,
  output logic [DATA_W-1:0] digit_data,
  output logic [3:0]        anode
);
  rf_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
    .clk       (clk),
    .rst       (rst),
    .usr_req   (usr_req),
    .usr_addr  (usr_addr),
    .usr_data  (usr_data),
    .usr_ack   (usr_ack),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rf_w_ena  (rf_w_ena),
    .rf_w_addr (rf_w_addr),
    .rf_w_data (rf_w_data)
  );

  rf_disp_scan #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_DIV(REFRESH_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .page       (page),
    .rf_r_addr  (rf_r_addr),
    .rf_r_data  (rf_r_data),
    .digit_data (digit_data),
    .anode      (anode)
  );
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 8x4 register file.
module tb_rf_access_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       usr_req;
  logic [2:0] usr_addr;
  logic [3:0] usr_data;
  logic       usr_ack;
  logic       clr_start;
  logic       clr_busy;
  logic       page;
  logic       rf_w_ena;
  logic [2:0] rf_w_addr;
  logic [3:0] rf_w_data;
  logic [2:0] rf_r_addr;
  logic [3:0] rf_r_data;
  logic [3:0] digit_data;
  logic [3:0] anode;

  logic [3:0] q_regfile [8];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_w_ena) q_regfile[rf_w_addr] <= rf_w_data;
  assign rf_r_data = q_regfile[rf_r_addr];

  rf_access_ctrl #(.ADDR_W(3), .DATA_W(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .usr_req    (usr_req),
    .usr_addr   (usr_addr),
    .usr_data   (usr_data),
    .usr_ack    (usr_ack),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .page       (page),
    .rf_w_ena   (rf_w_ena),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .rf_r_addr  (rf_r_addr),
    .rf_r_data  (rf_r_data),
    .digit_data (digit_data),
    .anode      (anode)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_pack();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = q_regfile[i];
    return v;
  endfunction

  task automatic usr_write(input logic [2:0] a, input logic [3:0] d);
    logic got;
    got      = 1'b0;
    usr_req  = 1'b1;
    usr_addr = a;
    usr_data = d;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = usr_ack;
    end
    chk("usr_write_ack", {31'd0, got}, 32'd1);
    usr_req = 1'b0;
    step();
    step();
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) usr_write(3'(i), 4'(i + 1));
  endtask

  initial begin
    int  nena, nack;
    logic found;
    logic [3:0] prev;

    rst = 1'b0; usr_req = 1'b0; usr_addr = '0; usr_data = '0;
    clr_start = 1'b0; page = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_anode", 32'(anode), 32'hE);
    chk("rst_digit", 32'(digit_data), 32'h0);
    chk("rst_ack", 32'(usr_ack), 32'h0);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_wena", 32'(rf_w_ena), 32'h0);
    chk("rst_waddr", 32'(rf_w_addr), 32'h0);
    rst = 1'b1;
    step();

    // Held user write: one write at +1, one ack at +2, nothing more
    usr_req = 1'b1; usr_addr = 3'd5; usr_data = 4'hA;
    step();
    chk("uw_ena", 32'(rf_w_ena), 32'h1);
    chk("uw_addr", 32'(rf_w_addr), 32'h5);
    chk("uw_data", 32'(rf_w_data), 32'hA);
    chk("uw_ack_early", 32'(usr_ack), 32'h0);
    step();
    chk("uw_ack", 32'(usr_ack), 32'h1);
    chk("uw_ena_off", 32'(rf_w_ena), 32'h0);
    nena = 0; nack = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      nena += int'(rf_w_ena);
      nack += int'(usr_ack);
    end
    chk("uw_held_ena", 32'(nena), 32'h0);
    chk("uw_held_ack", 32'(nack), 32'h0);
    usr_req = 1'b0;
    step(); step();
    chk("uw_mem5", 32'(q_regfile[5]), 32'hA);

    // Clear sweep over preloaded contents
    preload();
    chk("pre_mem", mem_pack(), 32'h8765_4321);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("clr_busy", 32'(clr_busy), 32'h1);
      chk("clr_ena", 32'(rf_w_ena), 32'h1);
      chk("clr_addr", 32'(rf_w_addr), 32'(k));
      chk("clr_data", 32'(rf_w_data), 32'h0);
      step();
    end
    chk("clr_done_busy", 32'(clr_busy), 32'h0);
    chk("clr_done_ena", 32'(rf_w_ena), 32'h0);
    chk("clr_mem", mem_pack(), 32'h0);

    // Clear and user request together: clear first, then the write
    preload();
    clr_start = 1'b1; usr_req = 1'b1; usr_addr = 3'd2; usr_data = 4'h7;
    step();
    clr_start = 1'b0;
    chk("ct_busy", 32'(clr_busy), 32'h1);
    chk("ct_addr0", 32'(rf_w_addr), 32'h0);
    nack = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      nack += int'(usr_ack);
    end
    chk("ct_no_ack", 32'(nack), 32'h0);
    chk("ct_addr7", 32'(rf_w_addr), 32'h7);
    step();
    chk("ct_busy_off", 32'(clr_busy), 32'h0);
    chk("ct_ena_off", 32'(rf_w_ena), 32'h0);
    step();
    chk("ct_uw_ena", 32'(rf_w_ena), 32'h1);
    chk("ct_uw_addr", 32'(rf_w_addr), 32'h2);
    chk("ct_uw_data", 32'(rf_w_data), 32'h7);
    step();
    chk("ct_ack", 32'(usr_ack), 32'h1);
    usr_req = 1'b0;
    step(); step();
    chk("ct_mem", mem_pack(), 32'h0000_0700);

    // Display scan on page 1
    usr_write(3'd4, 4'h1);
    usr_write(3'd5, 4'h2);
    usr_write(3'd6, 4'h3);
    usr_write(3'd7, 4'h4);
    page = 1'b1;
    found = 1'b0;
    prev = anode;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = (prev == 4'b0111) && (anode == 4'b1110);
      prev = anode;
    end
    chk("scan_sync", 32'(found), 32'h1);
    for (int j = 0; j < 4; j++) begin
      chk("scan_anode", 32'(anode), 32'(~(4'b0001 << j) & 4'hF));
      chk("scan_raddr", 32'(rf_r_addr), 32'(4 + j));
      step();
      chk("scan_digit", 32'(digit_data), 32'(j + 1));
      step(); step(); step();
    end
    chk("scan_wrap", 32'(anode), 32'hE);
    page = 1'b0;
    step();
    chk("page_anode", 32'(anode), 32'hE);
    chk("page_raddr", 32'(rf_r_addr), 32'h0);
    chk("page_digit", 32'(digit_data), 32'h0);

    // Reset in the middle of a clear
    preload();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step(); step(); step();
    chk("mid_addr3", 32'(rf_w_addr), 32'h3);
    rst = 1'b0;
    step();
    chk("mid_busy", 32'(clr_busy), 32'h0);
    chk("mid_ena", 32'(rf_w_ena), 32'h0);
    chk("mid_anode", 32'(anode), 32'hE);
    rst = 1'b1;
    step();
    chk("mid_mem", mem_pack(), 32'h8765_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
